// File: rtl/angle_pkg.sv
// Shared definitions for the angle tracker: 2Q13 angle constants, the angle
// type and the processing FSM states.
package angle_pkg;

    localparam int PI_Q13     = 25736;
    localparam int TWO_PI_Q13 = 51472;

    typedef logic signed [15:0] angle_t;

    typedef enum logic [1:0] {
        WAIT,
        DIFF,
        UPDATE,
        EMIT
    } state_e;

endpackage

// File: rtl/angle_wrap.sv
// Combinational wrap of a 17-bit signed 2Q13 angle back into [-PI, PI]
// by a single +/- TWO_PI correction.
module angle_wrap
    import angle_pkg::*;
(
    input  logic signed [16:0] in_val,
    output logic signed [16:0] out_val
);

    localparam logic signed [16:0] PI17     = 17'(PI_Q13);
    localparam logic signed [16:0] TWO_PI17 = 17'(TWO_PI_Q13);

    // NOTE: out_val gets a default first so no path through the block can infer a latch.
    always_comb begin
        out_val = in_val;
        if (in_val > PI17) begin
            out_val = in_val - TWO_PI17;
        end else if (in_val < -PI17) begin
            out_val = in_val + TWO_PI17;
        end
    end

endmodule

// File: rtl/angle_tracker.sv
// Wrap-aware exponential smoother with lock detection for CORDIC phase angles.
// Optional idle timeout that discards the estimate: define ANGLE_TRACKER_TIMEOUT_EN.
module angle_tracker
    import angle_pkg::*;
#(
    parameter int ALPHA_SHIFT    = 3,
    parameter int LOCK_THRESH    = 1024,
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic signed [15:0] s_angle_tdata,
    input  logic               s_angle_tvalid,
    output logic               s_angle_tready,
    output logic signed [15:0] m_angle_tdata,
    output logic               m_angle_tvalid,
    input  logic               m_angle_tready,
    output logic               locked_out
);

    localparam int LCW = $clog2(LOCK_COUNT + 1);

    state_e            state_q, state_d;
    angle_t            sample_q, sample_d;
    angle_t            est_q, est_d;
    logic signed [16:0] diff_q, diff_d;
    logic              have_est_q, have_est_d;
    logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic              s_ready_q, s_ready_d;
    logic              m_valid_q, m_valid_d;

    logic               accept;
    logic               tmo_hit;
    logic signed [16:0] diff_raw, diff_w, step, diff_abs, sum_raw, sum_w;

    assign accept   = s_ready_q && s_angle_tvalid;
    assign diff_raw = {sample_q[15], sample_q} - {est_q[15], est_q};
    assign step     = diff_q >>> ALPHA_SHIFT;
    assign diff_abs = diff_q[16] ? -diff_q : diff_q;
    assign sum_raw  = {est_q[15], est_q} + step;

    angle_wrap u_wrap_diff (.in_val(diff_raw), .out_val(diff_w));
    angle_wrap u_wrap_sum  (.in_val(sum_raw),  .out_val(sum_w));

`ifdef ANGLE_TRACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // An accept on the same edge as expiry wins: the counter just clears.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;
        if (accept) begin
            tmo_cnt_d = '0;
        end else if (state_q == WAIT && have_est_q) begin
            if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit   = 1'b1;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) tmo_cnt_q <= '0;
        else           tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        est_d      = est_q;
        diff_d     = diff_q;
        have_est_d = have_est_q;
        lock_cnt_d = lock_cnt_q;
        s_ready_d  = s_ready_q;
        m_valid_d  = m_valid_q;
        case (state_q)
            WAIT: begin
                s_ready_d = 1'b1;
                if (accept) begin
                    sample_d  = s_angle_tdata;
                    s_ready_d = 1'b0;
                    state_d   = DIFF;
                end else if (tmo_hit) begin
                    have_est_d = 1'b0;
                    lock_cnt_d = '0;
                end
            end
            DIFF: begin
                diff_d  = diff_w;
                state_d = UPDATE;
            end
            UPDATE: begin
                if (!have_est_q) begin
                    est_d      = sample_q;
                    lock_cnt_d = '0;
                    have_est_d = 1'b1;
                end else begin
                    est_d = angle_t'(sum_w);
                    if (diff_abs <= 17'(LOCK_THRESH)) begin
                        if (lock_cnt_q != LCW'(LOCK_COUNT)) lock_cnt_d = lock_cnt_q + LCW'(1);
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
                m_valid_d = 1'b1;
                state_d   = EMIT;
            end
            EMIT: begin
                if (m_angle_tready) begin
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    state_d   = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase
        locked_d = (lock_cnt_d == LCW'(LOCK_COUNT));
    end

    // NOTE: sequential state uses non-blocking assignments only; every register, including the estimate, has an async reset value.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= WAIT;
            sample_q   <= '0;
            est_q      <= '0;
            diff_q     <= '0;
            have_est_q <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            est_q      <= est_d;
            diff_q     <= diff_d;
            have_est_q <= have_est_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign s_angle_tready = s_ready_q;
    assign m_angle_tvalid = m_valid_q;
    assign m_angle_tdata  = est_q;
    assign locked_out     = locked_q;

endmodule

// File: tb/tb_angle_tracker.sv
// Directed self-checking bench for angle_tracker: latency, smoothing, wrap,
// lock, backpressure and idle-timeout behaviour with hand-computed values.
module tb_angle_tracker;

    logic               clk_in = 1'b0;
    logic               rst_n_in;
    logic signed [15:0] s_angle_tdata;
    logic               s_angle_tvalid;
    logic               s_angle_tready;
    logic signed [15:0] m_angle_tdata;
    logic               m_angle_tvalid;
    logic               m_angle_tready;
    logic               locked_out;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    angle_tracker #(
        .ALPHA_SHIFT(3),
        .LOCK_THRESH(1024),
        .LOCK_COUNT(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .s_angle_tdata(s_angle_tdata),
        .s_angle_tvalid(s_angle_tvalid),
        .s_angle_tready(s_angle_tready),
        .m_angle_tdata(m_angle_tdata),
        .m_angle_tvalid(m_angle_tvalid),
        .m_angle_tready(m_angle_tready),
        .locked_out(locked_out)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n_in       = 1'b0;
        s_angle_tvalid = 1'b0;
        s_angle_tdata  = '0;
        m_angle_tready = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    // Starts and ends on a falling edge; m_angle_tready is expected high.
    task automatic send(input string tag, input logic signed [15:0] a,
                        input logic signed [15:0] exp_d, input logic exp_l);
        int n;
        n = 0;
        while (!s_angle_tready && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        chk({tag, "_in_rdy"}, 32'(s_angle_tready), 1);
        s_angle_tdata  = a;
        s_angle_tvalid = 1'b1;
        @(negedge clk_in);
        s_angle_tvalid = 1'b0;
        n = 0;
        while (!m_angle_tvalid && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        chk({tag, "_out_vld"}, 32'(m_angle_tvalid), 1);
        chk({tag, "_data"}, m_angle_tdata, exp_d);
        chk({tag, "_lock"}, 32'(locked_out), 32'(exp_l));
        @(negedge clk_in);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held.
        rst_n_in       = 1'b0;
        s_angle_tvalid = 1'b0;
        s_angle_tdata  = '0;
        m_angle_tready = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("rst_s_ready", 32'(s_angle_tready), 0);
        chk("rst_m_valid", 32'(m_angle_tvalid), 0);
        chk("rst_m_data", m_angle_tdata, 0);
        chk("rst_locked", 32'(locked_out), 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("rdy_after_rst", 32'(s_angle_tready), 1);

        // First sample latency: accept edge, then valid after the 2nd following edge.
        s_angle_tdata  = 16'sd1000;
        s_angle_tvalid = 1'b1;
        @(negedge clk_in);
        s_angle_tvalid = 1'b0;
        chk("lat_rdy_drop", 32'(s_angle_tready), 0);
        chk("lat_vld_e0", 32'(m_angle_tvalid), 0);
        @(negedge clk_in);
        chk("lat_vld_e1", 32'(m_angle_tvalid), 0);
        @(negedge clk_in);
        chk("lat_vld_e2", 32'(m_angle_tvalid), 1);
        chk("lat_data", m_angle_tdata, 1000);
        chk("lat_lock", 32'(locked_out), 0);
        @(negedge clk_in);
        chk("lat_vld_done", 32'(m_angle_tvalid), 0);
        chk("lat_rdy_back", 32'(s_angle_tready), 1);

        // Basic smoothing from estimate 0.
        do_reset();
        send("init0a", 16'sd0, 16'sd0, 1'b0);
        send("pos800", 16'sd800, 16'sd100, 1'b0);
        do_reset();
        send("init0b", 16'sd0, 16'sd0, 1'b0);
        send("neg742", -16'sd742, -16'sd93, 1'b0);

        // Wrap across +/-PI on both the difference and the sum.
        do_reset();
        send("wrap_init", 16'sd25730, 16'sd25730, 1'b0);
        send("wrap", -16'sd25000, -16'sd25650, 1'b0);

        // Lock after four consistent samples following initialisation.
        do_reset();
        send("lock_init", 16'sd500, 16'sd500, 1'b0);
        send("lock_1", 16'sd500, 16'sd500, 1'b0);
        send("lock_2", 16'sd500, 16'sd500, 1'b0);
        send("lock_3", 16'sd500, 16'sd500, 1'b0);
        send("lock_4", 16'sd500, 16'sd500, 1'b1);
        send("unlock", 16'sd2500, 16'sd750, 1'b0);

        // Backpressure: estimate 750, sample 1000 gives 781, held for 10 cycles.
        m_angle_tready = 1'b0;
        s_angle_tdata  = 16'sd1000;
        s_angle_tvalid = 1'b1;
        @(negedge clk_in);
        s_angle_tvalid = 1'b0;
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < 10; i++) begin
            chk("bp_vld", 32'(m_angle_tvalid), 1);
            chk("bp_data", m_angle_tdata, 781);
            chk("bp_rdy", 32'(s_angle_tready), 0);
            @(negedge clk_in);
        end
        m_angle_tready = 1'b1;
        @(negedge clk_in);
        chk("bp_vld_done", 32'(m_angle_tvalid), 0);
        chk("bp_rdy_back", 32'(s_angle_tready), 1);

        // Idle timeout: locked at estimate 0, idle, then sample 3000.
        do_reset();
        send("tmo_init", 16'sd0, 16'sd0, 1'b0);
        send("tmo_1", 16'sd0, 16'sd0, 1'b0);
        send("tmo_2", 16'sd0, 16'sd0, 1'b0);
        send("tmo_3", 16'sd0, 16'sd0, 1'b0);
        send("tmo_4", 16'sd0, 16'sd0, 1'b1);
        repeat (20) @(negedge clk_in);
`ifdef ANGLE_TRACKER_TIMEOUT_EN
        chk("tmo_idle_lock", 32'(locked_out), 0);
        send("tmo_after", 16'sd3000, 16'sd3000, 1'b0);
`else
        chk("tmo_idle_lock", 32'(locked_out), 1);
        send("tmo_after", 16'sd3000, 16'sd375, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
